// File: rtl/data_sram_responder_pkg.sv
// Shared types for the data-side SRAM responder.
// Entry layout, size codes and LFSR helpers.
package data_sram_responder_pkg;

  localparam logic [1:0] SRAM_SIZE_B = 2'd0;
  localparam logic [1:0] SRAM_SIZE_H = 2'd1;
  localparam logic [1:0] SRAM_SIZE_W = 2'd2;

  localparam int DSRAM_CNT_W = 8;

  // cnt sits in the low bits so the queue can count down on the raw vector
  typedef struct packed {
    logic                   is_wr;
    logic [31:0]            rdata;
    logic [DSRAM_CNT_W-1:0] cnt;
  } dsram_entry_t;

  localparam int DSRAM_RESP_W = $bits(dsram_entry_t);

  localparam logic [15:0] DSRAM_LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/dsram_resp_queue.sv
// In-order response queue with per-entry countdown.
// An entry arriving ready on an empty queue is answered at once.
module dsram_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter  int OUTST = 2,
  localparam int CW    = $clog2(OUTST + 1),
  localparam int PW    = (OUTST > 1) ? $clog2(OUTST) : 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  dsram_entry_t push_e,
  output logic         head_ready,
  output dsram_entry_t head_e,
  output logic [CW-1:0] count
);

  logic [DSRAM_RESP_W-1:0] ent_q [OUTST];
  logic [DSRAM_RESP_W-1:0] ent_d [OUTST];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [CW-1:0] cnt_q;
  dsram_entry_t  head_q;
  dsram_entry_t  push_s;
  logic          empty;
  logic          bypass;
  logic          pop;
  logic          store;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head_q     = dsram_entry_t'(ent_q[rp_q]);
    empty      = (cnt_q == '0);
    bypass     = push && empty && (push_e.cnt == '0);
    pop        = !empty && (head_q.cnt == '0);
    store      = push && !bypass;
    head_ready = bypass || pop;
    head_e     = bypass ? push_e : head_q;
    push_s     = push_e;
    // the push edge itself counts as one elapsed cycle
    if (push_e.cnt != '0)
      push_s.cnt = push_e.cnt - 1'b1;
    for (int i = 0; i < OUTST; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i][DSRAM_CNT_W-1:0] != '0)
        ent_d[i][DSRAM_CNT_W-1:0] =
          ent_q[i][DSRAM_CNT_W-1:0] - 1'b1;
      if (store && (wp_q == PW'(i)))
        ent_d[i] = push_s;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < OUTST; i++)
        ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < OUTST; i++)
        ent_q[i] <= ent_d[i];
      if (store) wp_q <= inc(wp_q);
      if (pop)   rp_q <= inc(rp_q);
      cnt_q <= cnt_q + CW'(store) - CW'(pop);
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like slave: byte-masked memory, in-order responses.
// Optional random stalls/latency with DATA_SRAM_RAND_DELAY_EN.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int MEM_AW  = 12,
  parameter int OUTST   = 2,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int CW = $clog2(OUTST + 1);

  logic [31:0]       mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic              hs;
  logic [CW-1:0]     count;
  logic              gate;
  logic [1:0]        extra;
  logic              head_ready;
  dsram_entry_t      push_e;
  dsram_entry_t      head_e;
  logic              unused_ok;

  assign idx = data_sram_addr[MEM_AW+1:2];

`ifdef DATA_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= DSRAM_LFSR_SEED;
    else         lfsr_q <= lfsr_next(lfsr_q);
  end

  assign gate  = (lfsr_q[1:0] != 2'b00);
  assign extra = lfsr_q[3:2];
`else
  assign gate  = 1'b1;
  assign extra = 2'b00;
`endif

  assign data_sram_addr_ok =
    resetn && (count < CW'(OUTST)) && gate;
  assign hs = data_sram_req && data_sram_addr_ok;

  // read data is the word before any same-edge write (never both)
  always_comb begin
    push_e.is_wr = data_sram_wr;
    push_e.rdata = mem[idx];
    push_e.cnt   = DSRAM_CNT_W'(LATENCY - 1)
                 + DSRAM_CNT_W'(extra);
  end

  always_ff @(posedge clk) begin
    if (hs && data_sram_wr) begin
      for (int i = 0; i < 4; i++)
        if (data_sram_wstrb[i])
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
  end

  dsram_resp_queue #(.OUTST(OUTST)) u_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (hs),
    .push_e     (push_e),
    .head_ready (head_ready),
    .head_e     (head_e),
    .count      (count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sram_data_ok <= 1'b0;
      data_sram_rdata   <= '0;
    end else begin
      data_sram_data_ok <= head_ready;
      if (head_ready)
        data_sram_rdata <= head_e.is_wr ? '0 : head_e.rdata;
    end
  end

  assign unused_ok = ^{data_sram_size == SRAM_SIZE_B,
                       data_sram_size == SRAM_SIZE_H,
                       data_sram_size == SRAM_SIZE_W,
                       data_sram_addr[1:0],
                       data_sram_addr[31:MEM_AW+2]};

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench: two responders (LATENCY 1 and 3, OUTST 2)
// driven with directed and random traffic against a word-array model.
module tb_data_sram_responder;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   phase = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam logic [31:0] BASE = 32'h200;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        aok;
    logic        dok;
    logic [31:0] rd;

    exp_t      sb[$];
    bit [31:0] mm [int];
    int        hs_cnt = 0;
    int        drv_fail = 0;
    bit        done = 0;
    bit        rst_ready = 0;

    data_sram_responder #(
      .MEM_AW(12), .OUTST(2), .LATENCY(LAT)
    ) u_dut (
      .clk               (clk),
      .resetn            (resetn),
      .data_sram_req     (req),
      .data_sram_wr      (wr),
      .data_sram_size    (size),
      .data_sram_wstrb   (wstrb),
      .data_sram_addr    (addr),
      .data_sram_wdata   (wdata),
      .data_sram_addr_ok (aok),
      .data_sram_data_ok (dok),
      .data_sram_rdata   (rd)
    );

    // monitor: responses, addr_ok, and recording of accepted requests
    always @(negedge clk) begin
      exp_t        e;
      int          wi;
      logic [31:0] w;
      if (!resetn) begin
        sb.delete();
        checks++;
        if (dok !== 1'b0 || aok !== 1'b0 || rd !== 32'h0) begin
          failures++;
          $display("FAIL reset_state[%0d] data_ok=%b addr_ok=%b rdata=%h required 0 0 00000000",
                   g, dok, aok, rd);
        end
      end else begin
        if (dok === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_data_ok[%0d] cycle=%0d rdata=%h required no response",
                     g, cyc, rd);
          end else begin
            e = sb.pop_front();
`ifdef DATA_SRAM_RAND_DELAY_EN
            if (rd !== e.d || cyc < e.due) begin
`else
            if (rd !== e.d || cyc != e.due) begin
`endif
              failures++;
              $display("FAIL response[%0d] rdata=%h cycle=%0d required rdata=%h cycle=%0d",
                       g, rd, cyc, e.d, e.due);
            end
          end
        end
`ifndef DATA_SRAM_RAND_DELAY_EN
        else if (sb.size() > 0 && sb[0].due <= cyc) begin
          checks++;
          failures++;
          $display("FAIL missing_data_ok[%0d] cycle=%0d data_ok=%b required 1 at cycle %0d",
                   g, cyc, dok, sb[0].due);
          void'(sb.pop_front());
        end
`endif
        checks++;
`ifdef DATA_SRAM_RAND_DELAY_EN
        if (aok === 1'b1 && sb.size() >= 2) begin
          failures++;
          $display("FAIL addr_ok_full[%0d] addr_ok=%b outstanding=%0d required addr_ok=0",
                   g, aok, sb.size());
        end
`else
        if (aok !== (sb.size() < 2)) begin
          failures++;
          $display("FAIL addr_ok[%0d] cycle=%0d addr_ok=%b required %b",
                   g, cyc, aok, sb.size() < 2);
        end
`endif
        if (req === 1'b1 && aok === 1'b1) begin
          wi = int'((addr / 4) % 4096);
          w  = mm.exists(wi) ? mm[wi] : 32'h0;
          if (wr) begin
            for (int i = 0; i < 4; i++)
              if (wstrb[i]) w[8*i +: 8] = wdata[8*i +: 8];
            mm[wi] = w;
            e.d = 32'h0;
          end else begin
            e.d = w;
          end
          e.due = cyc + LAT;
          sb.push_back(e);
          hs_cnt++;
        end
      end
    end

    task automatic issue(input bit w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
      int start;
      int t;
      start = hs_cnt;
      t = 0;
      wr = w; wstrb = s; addr = a; wdata = d;
      size = 2'($urandom_range(0, 3));
      req = 1'b1;
      do begin
        @(negedge clk); #1;
        t++;
      end while (hs_cnt == start && t < 200);
      if (hs_cnt == start) begin
        drv_fail++;
        $display("FAIL handshake_timeout[%0d] addr=%h addr_ok never seen", g, a);
      end
      @(posedge clk); #1;
      req = 1'b0;
    endtask

    initial begin
      int t;
      int start;
      logic [31:0] a;
      req = 0; wr = 0; size = 0; wstrb = 0; addr = 0; wdata = 0;
      wait (phase == 1);
      @(posedge clk); #1;
      for (int k = 0; k < 16; k++)
        issue(1'b1, 4'hF, BASE + 32'(4 * k), $urandom);
      issue(1'b1, 4'hF, 32'h100, 32'h11223344);
      issue(1'b0, 4'h0, 32'h100, 32'h0);
      issue(1'b1, 4'b0100, 32'h100, 32'hAAAAAAAA);
      issue(1'b0, 4'h0, 32'h100, 32'h0);
      issue(1'b1, 4'h0, 32'h100, 32'hFFFFFFFF);
      for (int k = 0; k < 3; k++)
        issue(1'b0, 4'h0, 32'h100, 32'h0);
      for (int n = 0; n < 500; n++) begin
        if ($urandom_range(0, 7) == 0) a = 32'h100;
        else a = BASE + 32'(4 * $urandom_range(0, 15));
        a[31:14] = 18'($urandom);
        a[1:0]   = 2'($urandom);
        issue(1'($urandom), 4'($urandom), a, $urandom);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      t = 0;
      while (sb.size() != 0 && t < 200) begin
        @(negedge clk); #1;
        t++;
      end
      if (sb.size() != 0) begin
        drv_fail++;
        $display("FAIL drain_timeout[%0d] pending=%0d required 0", g, sb.size());
      end
      done = 1;
      if (g == 1) begin
        wait (phase == 2);
        @(posedge clk); #1;
        wr = 1'b0; wstrb = 4'h0; addr = 32'h100; size = 2'd2;
        start = hs_cnt;
        req = 1'b1;
        t = 0;
        while (hs_cnt < start + 2 && t < 400) begin
          @(negedge clk); #1;
          t++;
        end
        rst_ready = 1;
        @(posedge clk); #1;
        req = 1'b0;
      end
    end
  end

  initial begin
    int t;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    phase = 1;
    t = 0;
    while (!(gi[0].done && gi[1].done) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (!(gi[0].done && gi[1].done)) begin
      failures++;
      $display("FAIL traffic_timeout done=%b%b required 11",
               gi[0].done, gi[1].done);
    end
    phase = 2;
    t = 0;
    while (!gi[1].rst_ready && t < 1000) begin
      @(negedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      failures += (g == 0) ? gi[0].drv_fail : gi[1].drv_fail;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
